// File: rtl/cspi_pkg.sv
// Shared definitions for the clocked-SPI slave: FSM encoding and the MISO fill byte.
// Pure types and constants, so there is no latency and no flow control here.
package cspi_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'h0,
      S_SHIFT = 2'h1,
      S_BYTE  = 2'h2
   } cspi_state_e;

   localparam logic [7:0] MISO_FILL = 8'h00;

   function automatic logic [7:0] shift_in(input logic [7:0] cur, input logic bit_in);
      return {cur[6:0], bit_in};
   endfunction

endpackage

// File: rtl/cspi_sync.sv
// Multi-flop synchronizer for signals arriving from another clock domain; DEPTH cycles latency.
// No flow control: it samples every clk_sys cycle.
module cspi_sync
   import cspi_pkg::*;
#(
   parameter int               WIDTH   = 1,
   parameter int               DEPTH   = 2,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk_sys,
   input  logic             rst,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] stg_q [DEPTH];

   always_ff @(posedge clk_sys) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            stg_q[i] <= RST_VAL;
         end
      end else begin
         stg_q[0] <= d_i;
         for (int i = 1; i < DEPTH; i++) begin
            stg_q[i] <= stg_q[i-1];
         end
      end
   end

   assign q_o = stg_q[DEPTH-1];

endmodule

// File: rtl/cspi_slave.sv
// SPI mode-0 slave oversampled by clk_sys; byte strobe SYNC_STG+1 cycles after the 8th sclk rise.
// No backpressure on ctrl_dvld; optional byte timeout when CSPI_BYTE_TO_EN is defined.
module cspi_slave
   import cspi_pkg::*;
#(
   parameter int          SYNC_STG = 2,
   parameter logic [19:0] TO_CYC   = 20'd100_000
) (
   input  logic       clk_sys,
   input  logic       rst,
   input  logic       cspi_sclk,
   input  logic       cspi_csn,
   input  logic       cspi_mosi,
   output logic       cspi_miso,
   output logic [7:0] ctrl_data,
   output logic       ctrl_dvld,
   input  logic [7:0] ctrl_q,
   input  logic       ctrl_qvld,
   output logic       cspi_busy
);

   logic sclk_s, csn_s, mosi_s;
   logic sclk_prev_q, csn_prev_q;
   logic sclk_rise, sclk_fall, csn_rise, csn_fall;
   logic to_fire;

   cspi_state_e state_q, state_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic [7:0]  rx_shift_q, rx_shift_d;
   logic [7:0]  tx_shift_q, tx_shift_d;
   logic [7:0]  tx_hold_q, tx_hold_d;
   logic        tx_pend_q, tx_pend_d;
   logic        tx_load;
   logic [7:0]  ctrl_data_q, ctrl_data_d;
   logic        ctrl_dvld_q, ctrl_dvld_d;

   cspi_sync #(.WIDTH(1), .DEPTH(SYNC_STG), .RST_VAL(1'b0)) u_sync_sclk (
      .clk_sys (clk_sys),
      .rst     (rst),
      .d_i     (cspi_sclk),
      .q_o     (sclk_s)
   );

   cspi_sync #(.WIDTH(1), .DEPTH(SYNC_STG), .RST_VAL(1'b1)) u_sync_csn (
      .clk_sys (clk_sys),
      .rst     (rst),
      .d_i     (cspi_csn),
      .q_o     (csn_s)
   );

   cspi_sync #(.WIDTH(1), .DEPTH(SYNC_STG), .RST_VAL(1'b0)) u_sync_mosi (
      .clk_sys (clk_sys),
      .rst     (rst),
      .d_i     (cspi_mosi),
      .q_o     (mosi_s)
   );

   assign sclk_rise = sclk_s & ~sclk_prev_q;
   assign sclk_fall = ~sclk_s & sclk_prev_q;
   assign csn_rise  = csn_s & ~csn_prev_q;
   assign csn_fall  = ~csn_s & csn_prev_q;

`ifdef CSPI_BYTE_TO_EN
   logic [19:0] to_cnt_q, to_cnt_d;

   always_comb begin
      to_cnt_d = '0;
      to_fire  = 1'b0;
      if (state_q == S_SHIFT && bit_cnt_q != 3'd0 && !sclk_rise && !sclk_fall) begin
         if (to_cnt_q == TO_CYC - 20'd1) begin
            to_fire = 1'b1;
         end else begin
            to_cnt_d = to_cnt_q + 20'd1;
         end
      end
   end

   always_ff @(posedge clk_sys) begin
      if (rst) begin
         to_cnt_q <= '0;
      end else begin
         to_cnt_q <= to_cnt_d;
      end
   end
`else
   assign to_fire = 1'b0;

   // TO_CYC only takes effect in the timeout build.
   if (TO_CYC == 20'd0) begin : g_to_cyc_unused
   end
`endif

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      rx_shift_d = rx_shift_q;
      tx_shift_d = tx_shift_q;
      tx_hold_d  = tx_hold_q;
      tx_pend_d  = tx_pend_q;
      tx_load    = 1'b0;

      if (ctrl_qvld) begin
         tx_hold_d = ctrl_q;
         tx_pend_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (csn_fall) begin
               state_d = S_SHIFT;
               tx_load = 1'b1;
            end
         end
         S_SHIFT: begin
            if (sclk_rise) begin
               rx_shift_d = shift_in(rx_shift_q, mosi_s);
               bit_cnt_d  = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  state_d = S_BYTE;
               end
            end else if (to_fire) begin
               bit_cnt_d  = '0;
               rx_shift_d = '0;
            end
            // The falling edge after the 8th rise would eat bit 7 of the freshly loaded byte.
            if (sclk_fall && bit_cnt_q != 3'd0) begin
               tx_shift_d = {tx_shift_q[6:0], 1'b0};
            end
         end
         S_BYTE: begin
            state_d = S_SHIFT;
            tx_load = 1'b1;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (tx_load) begin
         if (ctrl_qvld) begin
            tx_shift_d = ctrl_q;
            tx_pend_d  = 1'b0;
         end else if (tx_pend_q) begin
            tx_shift_d = tx_hold_q;
            tx_pend_d  = 1'b0;
         end else begin
            tx_shift_d = MISO_FILL;
         end
      end

      if (csn_rise) begin
         state_d    = S_IDLE;
         bit_cnt_d  = '0;
         rx_shift_d = '0;
      end
   end

   always_comb begin
      ctrl_dvld_d = (state_q == S_BYTE);
      ctrl_data_d = (state_q == S_BYTE) ? rx_shift_q : ctrl_data_q;
   end

   always_ff @(posedge clk_sys) begin
      if (rst) begin
         state_q     <= S_IDLE;
         sclk_prev_q <= 1'b0;
         csn_prev_q  <= 1'b1;
         bit_cnt_q   <= '0;
         rx_shift_q  <= '0;
         tx_shift_q  <= '0;
         tx_hold_q   <= '0;
         tx_pend_q   <= 1'b0;
         ctrl_data_q <= '0;
         ctrl_dvld_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sclk_prev_q <= sclk_s;
         csn_prev_q  <= csn_s;
         bit_cnt_q   <= bit_cnt_d;
         rx_shift_q  <= rx_shift_d;
         tx_shift_q  <= tx_shift_d;
         tx_hold_q   <= tx_hold_d;
         tx_pend_q   <= tx_pend_d;
         ctrl_data_q <= ctrl_data_d;
         ctrl_dvld_q <= ctrl_dvld_d;
      end
   end

   assign ctrl_data = ctrl_data_q;
   assign ctrl_dvld = ctrl_dvld_q;
   assign cspi_busy = ~csn_s;
   assign cspi_miso = csn_s ? 1'b0 : tx_shift_q[7];

endmodule

// File: tb/tb_cspi_slave.sv
// Directed bench for cspi_slave: a host model drives SPI frames, a byte-level model predicts strobes.
module tb_cspi_slave;

   localparam int S  = 2;
   localparam int HP = 5;

   logic       clk_sys   = 1'b0;
   logic       rst       = 1'b1;
   logic       cspi_sclk = 1'b0;
   logic       cspi_csn  = 1'b1;
   logic       cspi_mosi = 1'b0;
   logic [7:0] ctrl_q    = 8'h00;
   logic       ctrl_qvld = 1'b0;
   logic       cspi_miso;
   logic [7:0] ctrl_data;
   logic       ctrl_dvld;
   logic       cspi_busy;

   always #5 clk_sys = ~clk_sys;

   cspi_slave #(.SYNC_STG(S), .TO_CYC(20'd100)) dut (
      .clk_sys   (clk_sys),
      .rst       (rst),
      .cspi_sclk (cspi_sclk),
      .cspi_csn  (cspi_csn),
      .cspi_mosi (cspi_mosi),
      .cspi_miso (cspi_miso),
      .ctrl_data (ctrl_data),
      .ctrl_dvld (ctrl_dvld),
      .ctrl_q    (ctrl_q),
      .ctrl_qvld (ctrl_qvld),
      .cspi_busy (cspi_busy)
   );

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Byte-level model: bits the host has clocked in, and the strobes they must produce.
   typedef struct {
      logic [7:0] b;
      int         due;
   } exp_t;

   exp_t       expq[$];
   logic [7:0] m_acc = 8'h00;
   int         m_n   = 0;

   task automatic model_rise(input logic b);
      exp_t e;
      m_acc = {m_acc[6:0], b};
      m_n++;
      if (m_n == 8) begin
         e.b   = m_acc;
         e.due = cyc + S + 2;
         expq.push_back(e);
         m_n = 0;
      end
   endtask

   always @(posedge clk_sys) cyc <= cyc + 1;

   logic [7:0] csn_h = 8'hFF;
   logic [7:0] rst_h = 8'hFF;
   always @(posedge clk_sys) begin
      csn_h <= {csn_h[6:0], cspi_csn};
      rst_h <= {rst_h[6:0], rst};
   end

   logic prev_dvld = 1'b0;
   int   dvld_cnt  = 0;
   exp_t ce;

   always @(negedge clk_sys) begin
      if (rst_h[0]) begin
         chk("rst_dvld", ctrl_dvld, 0);
         chk("rst_data", ctrl_data, 0);
         chk("rst_miso", cspi_miso, 0);
         chk("rst_busy", cspi_busy, 0);
      end else begin
         if (ctrl_dvld) begin
            dvld_cnt++;
            chk("dvld_one_cycle", prev_dvld, 0);
            chk("dvld_expected", expq.size() > 0, 1);
            if (expq.size() > 0) begin
               ce = expq.pop_front();
               chk("dvld_data", ctrl_data, ce.b);
               chk("dvld_latency", cyc, ce.due);
            end
         end else if (expq.size() > 0 && cyc > expq[0].due) begin
            chk("dvld_missing", ctrl_dvld, 1);
            void'(expq.pop_front());
         end
         if (rst_h[S:0] == '0) begin
            chk("busy", cspi_busy, !csn_h[S-1]);
            if (csn_h[S-1]) chk("miso_idle", cspi_miso, 0);
         end
      end
      prev_dvld = ctrl_dvld;
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk_sys);
   endtask

   task automatic csn_low();
      @(negedge clk_sys);
      cspi_csn = 1'b0;
      wait_cyc(HP);
   endtask

   task automatic csn_high();
      wait_cyc(HP);
      cspi_csn = 1'b1;
      m_n = 0;
      wait_cyc(3 * HP);
   endtask

   task automatic q_pulse(input logic [7:0] v);
      @(negedge clk_sys);
      ctrl_q    = v;
      ctrl_qvld = 1'b1;
      @(negedge clk_sys);
      ctrl_qvld = 1'b0;
   endtask

   // Mode 0: mosi changes with sclk low, both sides sample on the rise; miso captured at the rise.
   task automatic send_bits(input logic [7:0] tx, input int nbits, input int qbit,
                            input logic [7:0] qv, output logic [7:0] rx);
      rx = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         cspi_mosi = tx[7-i];
         if (i == qbit) begin
            ctrl_q    = qv;
            ctrl_qvld = 1'b1;
            @(negedge clk_sys);
            ctrl_qvld = 1'b0;
            wait_cyc(HP - 1);
         end else begin
            wait_cyc(HP);
         end
         rx = {rx[6:0], cspi_miso};
         cspi_sclk = 1'b1;
         model_rise(tx[7-i]);
         wait_cyc(HP);
         cspi_sclk = 1'b0;
      end
   endtask

   task automatic send_byte(input logic [7:0] tx, output logic [7:0] rx);
      send_bits(tx, 8, -1, 8'h00, rx);
   endtask

   logic [7:0] r1, r2, r3;
   logic [7:0] bytes4 [4];
   int         base;

   initial begin
      bytes4[0] = 8'h12; bytes4[1] = 8'h34; bytes4[2] = 8'h56; bytes4[3] = 8'h78;

      wait_cyc(4);
      chk("reset_data", ctrl_data, 8'h00);
      chk("reset_busy", cspi_busy, 0);
      @(negedge clk_sys);
      rst = 1'b0;
      wait_cyc(6);

      // Single byte, nothing queued for the host.
      base = dvld_cnt;
      csn_low();
      send_byte(8'hA5, r1);
      csn_high();
      chk("a5_count", dvld_cnt - base, 1);
      chk("a5_data", ctrl_data, 8'hA5);
      chk("a5_miso", r1, 8'h00);
      wait_cyc(20);
      chk("a5_hold", ctrl_data, 8'hA5);

      // Four bytes in one frame.
      base = dvld_cnt;
      csn_low();
      for (int i = 0; i < 4; i++) send_byte(bytes4[i], r1);
      csn_high();
      chk("four_count", dvld_cnt - base, 4);
      chk("four_last", ctrl_data, 8'h78);

      // Response arriving mid byte 1 goes out in byte 2, then back to fill.
      csn_low();
      send_bits(8'h11, 8, 3, 8'h3C, r1);
      send_byte(8'h22, r2);
      send_byte(8'h33, r3);
      csn_high();
      chk("resp_b1", r1, 8'h00);
      chk("resp_b2", r2, 8'h3C);
      chk("resp_b3", r3, 8'h00);

      // Two responses while idle: the later one wins, loaded at the frame start.
      q_pulse(8'h11);
      q_pulse(8'h66);
      csn_low();
      send_byte(8'h44, r1);
      send_byte(8'h55, r2);
      csn_high();
      chk("lastwin_b1", r1, 8'h66);
      chk("lastwin_b2", r2, 8'h00);
      chk("lastwin_data", ctrl_data, 8'h55);

      // Frame aborted after 5 bits, then a clean byte.
      base = dvld_cnt;
      csn_low();
      send_bits(8'hFF, 5, -1, 8'h00, r1);
      csn_high();
      chk("abort_count", dvld_cnt - base, 0);
      csn_low();
      send_byte(8'hC3, r1);
      csn_high();
      chk("abort_next", ctrl_data, 8'hC3);
      chk("abort_total", dvld_cnt - base, 1);

      // Reset mid-byte; csn released while reset is held.
      base = dvld_cnt;
      csn_low();
      send_bits(8'h5A, 4, -1, 8'h00, r1);
      rst = 1'b1;
      m_n = 0;
      wait_cyc(3);
      chk("midrst_dvld", ctrl_dvld, 0);
      chk("midrst_data", ctrl_data, 8'h00);
      chk("midrst_miso", cspi_miso, 0);
      chk("midrst_busy", cspi_busy, 0);
      cspi_csn = 1'b1;
      wait_cyc(3);
      rst = 1'b0;
      wait_cyc(10);
      chk("midrst_count", dvld_cnt - base, 0);
      csn_low();
      send_byte(8'h81, r1);
      csn_high();
      chk("midrst_next", ctrl_data, 8'h81);

      // 3 bits, sclk stall, then a full byte.
      base = dvld_cnt;
      csn_low();
      send_bits(8'hA0, 3, -1, 8'h00, r1);
      wait_cyc(150);
`ifdef CSPI_BYTE_TO_EN
      m_n = 0;
`endif
      send_byte(8'hE7, r1);
      csn_high();
      chk("stall_count", dvld_cnt - base, 1);
`ifdef CSPI_BYTE_TO_EN
      chk("stall_data", ctrl_data, 8'hE7);
`else
      chk("stall_data", ctrl_data, 8'hBC);
`endif

      wait_cyc(20);
      chk("total_strobes", dvld_cnt, 13);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got cycle %0d required < 50000", cyc);
      $fatal(1);
   end

endmodule

// File: doc/cspi_slave.md
CSPI_SLAVE -- requirements
Module: cspi_slave

Interface
REQ-001 Parameter SYNC_STG, default 2, number of flip-flop synchronizer stages on cspi_sclk, cspi_csn and cspi_mosi (legal range 2..3).
REQ-002 Parameter TO_CYC, default 20'd100_000, byte-timeout length in clk_sys cycles; used only when CSPI_BYTE_TO_EN is defined.
REQ-003 clk_sys  input  1  system clock; the only clock in the block.
REQ-004 rst  input  1  reset, synchronous to clk_sys, active-high.
REQ-005 cspi_sclk  input  1  SPI clock from the external host, asynchronous to clk_sys; SPI mode 0 (CPOL=0, CPHA=0).
REQ-006 cspi_csn  input  1  SPI chip select, active-low, asynchronous.
REQ-007 cspi_mosi  input  1  SPI data from the host, MSB first.
REQ-008 cspi_miso  output  1  SPI data to the host, MSB first.
REQ-009 ctrl_data  output  8  received byte, valid while ctrl_dvld is high.
REQ-010 ctrl_dvld  output  1  one-cycle strobe marking one received byte.
REQ-011 ctrl_q  input  8  response byte from the downstream command codec.
REQ-012 ctrl_qvld  input  1  one-cycle strobe; ctrl_q is valid in that cycle.
REQ-013 cspi_busy  output  1  high while the synchronized cspi_csn is low.

Function
REQ-014 The block shall pass cspi_sclk, cspi_csn and cspi_mosi through SYNC_STG-stage synchronizers, and shall detect edges only on the synchronized copies.
REQ-015 The FSM shall have the states S_IDLE, S_SHIFT and S_BYTE.
REQ-016 Transitions:
- S_IDLE -> S_SHIFT on a falling edge of the synchronized csn.
- S_SHIFT -> S_BYTE on the 8th sclk rising edge.
- S_BYTE -> S_SHIFT unconditionally after one cycle.
- Any state -> S_IDLE on a synchronized csn rising edge.
REQ-017 In S_SHIFT, each sclk rising edge shall shift the synchronized mosi into the LSB of rx_shift and increment a 3-bit bit counter; the counter shall wrap from 7 to 0.
REQ-018 In S_BYTE, ctrl_dvld shall be high for exactly one cycle and ctrl_data shall equal the completed byte; ctrl_data shall hold that value until the next byte completes.
REQ-019 Latency: ctrl_dvld shall rise SYNC_STG+1 clk_sys cycles after the clk_sys edge that first samples the 8th sclk rising edge at the pin.
REQ-020 A synchronized csn rising edge with the bit counter non-zero shall discard the partial byte, produce no ctrl_dvld and clear the bit counter.
REQ-021 ctrl_qvld shall load ctrl_q into tx_hold and set tx_pend, in any state.
REQ-022 tx_shift shall be loaded at every byte boundary (csn falling edge, and S_BYTE):
- from tx_hold, clearing tx_pend, when tx_pend is set;
- with 8'h00 otherwise.
REQ-023 ctrl_qvld in the same cycle as a byte-boundary load shall be forwarded directly into tx_shift, with tx_pend left clear.
REQ-024 Each sclk falling edge in S_SHIFT shall shift tx_shift left by one bit; cspi_miso shall equal tx_shift[7] while csn is low and 1'b0 while csn is high.
REQ-025 A second ctrl_qvld before the byte boundary shall overwrite tx_hold (last value wins).
REQ-026 Maximum cspi_sclk frequency shall be clk_sys/8; behaviour above that rate is undefined.

Reset
REQ-027 While rst is high, the block shall reset:
- FSM to S_IDLE;
- synchronizer flops: csn to 1, sclk and mosi to 0;
- rx_shift, tx_shift, tx_hold, ctrl_data, bit counter and timeout counter to 0;
- tx_pend, ctrl_dvld, cspi_miso and cspi_busy to 0.
REQ-028 A reset asserted mid-byte shall drop the partial byte; after reset is released, reception shall resume only on the next csn falling edge.

Configuration
REQ-029 With CSPI_BYTE_TO_EN defined:
- in S_SHIFT with the bit counter non-zero, a counter shall count clk_sys cycles without an sclk edge;
- any sclk edge shall clear the counter;
- on reaching TO_CYC, the FSM shall clear the bit counter and rx_shift, stay in S_SHIFT and produce no ctrl_dvld.
REQ-030 Without CSPI_BYTE_TO_EN, the timeout counter logic shall be absent and a partial byte shall be discarded only by a csn rising edge or by reset.

Structure
REQ-031 Shared package cspi_pkg shall hold the FSM state encodings (S_IDLE=2'h0, S_SHIFT=2'h1, S_BYTE=2'h2) and the idle MISO fill byte constant 8'h00.
REQ-032 The synchronizer shall be a sub-module named cspi_sync, instantiated three times, with width 1 and depth SYNC_STG.

Verification
REQ-033 Host sends 8'hA5 with csn low -> exactly one ctrl_dvld pulse with ctrl_data=8'hA5; cspi_miso shifts out 8'h00.
REQ-034 Host sends 8'h12, 8'h34, 8'h56, 8'h78 in one csn frame -> four ctrl_dvld pulses carrying 12, 34, 56, 78 in that order.
REQ-035 ctrl_qvld with ctrl_q=8'h3C arrives mid-way through byte 1 -> MISO carries 8'h3C during byte 2 and 8'h00 during byte 3.
REQ-036 csn rises after 5 bits -> no ctrl_dvld pulse; the next frame byte 8'hC3 is received correctly.
REQ-037 rst is pulsed after bit 4 of a byte -> all outputs at their reset values; the next frame carrying 8'h81 gives ctrl_data=8'h81.
REQ-038 With CSPI_BYTE_TO_EN and TO_CYC=100: 3 bits, then sclk stalls 150 cycles, then 8 more bits of 8'hE7 -> exactly one ctrl_dvld pulse with ctrl_data=8'hE7.
